imem_boot_loader: RTL and testbench

- Upstream of the single-cycle CPU. Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port, holding the CPU in reset until the image is fully loaded.
- Releases the CPU (active-low reset output) only after a successful load. On a malformed image it parks in an error state with the CPU still held in reset.

---
 rtl/imem_boot_pkg.sv | 6 +
 rtl/imem_boot_loader_packer.sv | 34 +++
 rtl/imem_boot_loader.sv | 94 +++++++++
 tb/tb_imem_boot_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared FSM state encoding and framing constants for the instruction-memory boot loader
package imem_boot_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, CSUM, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_to_word_packer: collects accepted bytes little-endian into 32-bit words and pulses word_valid per word
module byte_to_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [23:0] shift;
  // Lower three bytes shift in from the top; the fourth byte completes the word, which then holds until the next one
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lane       <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        lane <= lane + 2'd1;
        if (lane == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {byte_data, shift};
          word_valid <= 1'b1;
        end else begin
          shift <= {byte_data, shift[23:8]};
        end
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte image into instruction memory and holds the CPU in reset until done.
// Optional IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte verified in state CSUM.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        error_o
);
  state_t      state, state_n;
  logic [15:0] count, word_idx, hdr_cnt;
  logic        acc, load_acc, word_end, last_word;
  logic [1:0]  lane;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_STATE = DONE;
`endif
  assign acc       = byte_valid_i & byte_ready_o;
  assign load_acc  = acc & (state == LOAD);
  assign word_end  = load_acc & (lane == 2'(BYTES_PER_WORD - 1));
  assign last_word = word_idx == count - 16'd1;
  assign hdr_cnt   = {byte_data_i, count[7:0]};
  byte_to_word_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .byte_en    (load_acc),
    .byte_data  (byte_data_i),
    .lane       (lane),
    .word_valid (imem_we_o),
    .word       (imem_wdata_o)
  );
  // State register; reset always restarts at the header
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= HDR0;
    else        state <= state_n;
  end
  // Next state: advance only on accepted bytes, DONE and ERROR are terminal
  always_comb begin
    state_n = state;
    case (state)
      HDR0:    state_n = acc ? HDR1 : HDR0;
      HDR1:    state_n = !acc ? HDR1 : hdr_cnt == 16'd0 ? END_STATE :
                         int'(hdr_cnt) > MAX_WORDS ? ERROR : LOAD;
      LOAD:    state_n = word_end && last_word ? END_STATE : LOAD;
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM:    state_n = !acc ? CSUM : csum == byte_data_i ? DONE : ERROR;
`endif
      default: state_n = state;
    endcase
  end
  // Header capture, write addressing and registered status outputs; ready follows the next state so it never waits on valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count        <= '0;
      word_idx     <= '0;
      imem_addr_o  <= '0;
      byte_ready_o <= 1'b0;
      cpu_rst_o    <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      byte_ready_o <= state_n inside {HDR0, HDR1, LOAD, CSUM};
      cpu_rst_o    <= state == DONE;
      done_o       <= state == DONE;
      error_o      <= state == ERROR;
      if (acc && state == HDR0) count[7:0] <= byte_data_i;
      if (acc && state == HDR1) count[15:8] <= byte_data_i;
      if (word_end) begin
        imem_addr_o <= BASE_ADDR + 32'(word_idx) * 32'(BYTES_PER_WORD);
        word_idx    <= word_idx + 16'd1;
      end
    end
  end
`ifdef IMEM_BOOT_CHECKSUM_EN
  // Running XOR over header and image bytes; the checksum byte itself is excluded
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   csum <= '0;
    else if (acc && state != CSUM) csum <= csum ^ byte_data_i;
  end
`endif
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o, imem_we_o, cpu_rst_o, done_o, error_o;
  logic [31:0] imem_addr_o, imem_wdata_o;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tb_xor = 8'h00;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];

  imem_boot_loader #(.MAX_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr_o, imem_wdata_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr_o, e.addr);
        chk("wr_data", imem_wdata_o, e.data);
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    byte_valid_i = 1'b0;
    tb_xor = 8'h00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid_i = 1'b1;
    byte_data_i = b;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!byte_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
      byte_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    tb_xor ^= b;
  endtask

  task automatic finish_image();
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(tb_xor);
`endif
  endtask

  task automatic expect_done();
    chk("done_not_yet", done_o, 0);
    @(negedge clk_i);
    chk("done", done_o, 1);
    chk("cpu_rst_released", cpu_rst_o, 1);
    chk("no_error", error_o, 0);
    chk("ready_low_done", byte_ready_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    logic [7:0] bs [4];
    int k;
    #12;
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_we", imem_we_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_wdata", imem_wdata_o, 0);
    chk("rst_cpu_rst", cpu_rst_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);

    // basic two-word load
    do_reset();
    push_wr(32'h0, 32'h00A00513);
    push_wr(32'h4, 32'h00B00593);
    foreach (bs[i]) bs[i] = 8'h00;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
    finish_image();
    expect_done();

    // zero-length image
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    finish_image();
    expect_done();
    repeat (3) @(negedge clk_i);

    // oversize count 1025
    do_reset();
    send_byte(8'h01); send_byte(8'h04);
    chk("oversize_ready", byte_ready_o, 0);
    @(negedge clk_i);
    chk("oversize_error", error_o, 1);
    chk("oversize_cpu_rst", cpu_rst_o, 0);
    chk("oversize_done", done_o, 0);
    byte_valid_i = 1'b1;
    byte_data_i = 8'hAA;
    repeat (4) @(negedge clk_i);
    byte_valid_i = 1'b0;
    chk("error_sticky", error_o, 1);
    chk("error_ready", byte_ready_o, 0);

    // count exactly MAX_WORDS is accepted
    do_reset();
    send_byte(8'h00); send_byte(8'h04);
    repeat (2) @(negedge clk_i);
    chk("max_no_error", error_o, 0);
    chk("max_ready", byte_ready_o, 1);

    // stalled single word
    do_reset();
    push_wr(32'h0, 32'h00A00513);
    send_byte(8'h01); send_byte(8'h00);
    pat = 7'b1101001;
    bs = '{8'h13, 8'h05, 8'hA0, 8'h00};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      byte_valid_i = pat[i];
      byte_data_i = pat[i] ? bs[k] : 8'hFF;
      @(negedge clk_i);
      if (pat[i]) begin
        tb_xor ^= bs[k];
        k++;
      end
    end
    byte_valid_i = 1'b0;
    finish_image();
    expect_done();

    // reset mid-load discards the partial word
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_ready", byte_ready_o, 0);
    chk("midrst_cpu_rst", cpu_rst_o, 0);
    chk("midrst_we", imem_we_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tb_xor = 8'h00;
    @(negedge clk_i);
    push_wr(32'h0, 32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    finish_image();
    expect_done();

`ifdef IMEM_BOOT_CHECKSUM_EN
    // good checksum
    do_reset();
    push_wr(32'h0, 32'h12345678);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h09);
    expect_done();
    // bad checksum
    do_reset();
    push_wr(32'h0, 32'h12345678);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h08);
    @(negedge clk_i);
    chk("csum_error", error_o, 1);
    chk("csum_cpu_rst", cpu_rst_o, 0);
    chk("csum_done", done_o, 0);
`endif

    repeat (3) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
